// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter: shares one data-memory channel between several LSU requesters.
// A round-robin scan picks one requester at a time. Its address and write data are
// captured at grant, so the memory side never sees later changes at the requester.
// The result is handed back through a per-requester ready bit. The arbiter waits for
// the owner to drop its valid before it arbitrates again.
module mem_rr_arbiter #(
    parameter  int NUM_REQUESTERS = 4,
    parameter  int ADDR_BITS      = 8,
    parameter  int DATA_BITS      = 8,
    localparam int ID_W           = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1
) (
    input  logic                                      clk,
    input  logic                                      reset,

    input  logic [NUM_REQUESTERS-1:0]                 req_read_valid,
    input  logic [NUM_REQUESTERS-1:0][ADDR_BITS-1:0]  req_read_address,
    output logic [NUM_REQUESTERS-1:0]                 req_read_ready,
    output logic [NUM_REQUESTERS-1:0][DATA_BITS-1:0]  req_read_data,

    input  logic [NUM_REQUESTERS-1:0]                 req_write_valid,
    input  logic [NUM_REQUESTERS-1:0][ADDR_BITS-1:0]  req_write_address,
    input  logic [NUM_REQUESTERS-1:0][DATA_BITS-1:0]  req_write_data,
    output logic [NUM_REQUESTERS-1:0]                 req_write_ready,

    output logic                                      mem_read_valid,
    output logic [ADDR_BITS-1:0]                      mem_read_address,
    input  logic                                      mem_read_ready,
    input  logic [DATA_BITS-1:0]                      mem_read_data,

    output logic                                      mem_write_valid,
    output logic [ADDR_BITS-1:0]                      mem_write_address,
    output logic [DATA_BITS-1:0]                      mem_write_data,
    input  logic                                      mem_write_ready,

    output logic                                      busy,
    output logic [ID_W-1:0]                           grant_id
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        READ_WAIT  = 2'd1,
        WRITE_WAIT = 2'd2,
        RELAY      = 2'd3
    } state_t;

    localparam logic [ID_W:0] NUM_W = (ID_W+1)'(NUM_REQUESTERS);

    // Cyclic index arithmetic modulo NUM_REQUESTERS (works for non-power-of-two counts).
    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base,
                                                 input logic [ID_W-1:0] off);
        logic [ID_W:0] sum;
        sum = {1'b0, base} + {1'b0, off};
        if (sum >= NUM_W) begin
            sum = sum - NUM_W;
        end
        return sum[ID_W-1:0];
    endfunction

    state_t                                    state, state_nxt;
    logic [ID_W-1:0]                           rr_ptr, rr_ptr_nxt;
    logic [ID_W-1:0]                           grant_id_nxt;
    logic                                      gnt_write, gnt_write_nxt;
    logic                                      mem_read_valid_nxt;
    logic [ADDR_BITS-1:0]                      mem_read_address_nxt;
    logic                                      mem_write_valid_nxt;
    logic [ADDR_BITS-1:0]                      mem_write_address_nxt;
    logic [DATA_BITS-1:0]                      mem_write_data_nxt;
    logic [NUM_REQUESTERS-1:0]                 req_read_ready_nxt;
    logic [NUM_REQUESTERS-1:0]                 req_write_ready_nxt;
    logic [NUM_REQUESTERS-1:0][DATA_BITS-1:0]  req_read_data_nxt;

    logic                                      scan_found;
    logic                                      scan_read;
    logic [ID_W-1:0]                           scan_id;
    logic [ID_W-1:0]                           cand;
    logic                                      owner_released;

    // Round-robin scan starting at rr_ptr; the first requester with any valid wins,
    // and a requester asking for both read and write is served read first.
    always_comb begin
        scan_found = 1'b0;
        scan_read  = 1'b0;
        scan_id    = '0;
        cand       = '0;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            cand = wrap_add(rr_ptr, ID_W'(i));
            if (!scan_found && (req_read_valid[cand] || req_write_valid[cand])) begin
                scan_found = 1'b1;
                scan_id    = cand;
                scan_read  = req_read_valid[cand];
            end
        end
    end

    // The owner has let go of the request it was served for.
    always_comb begin
        owner_released = gnt_write ? !req_write_valid[grant_id] : !req_read_valid[grant_id];
    end

    // Next-state and next-output logic for the arbitration FSM.
    always_comb begin
        state_nxt             = state;
        rr_ptr_nxt            = rr_ptr;
        grant_id_nxt          = grant_id;
        gnt_write_nxt         = gnt_write;
        mem_read_valid_nxt    = mem_read_valid;
        mem_read_address_nxt  = mem_read_address;
        mem_write_valid_nxt   = mem_write_valid;
        mem_write_address_nxt = mem_write_address;
        mem_write_data_nxt    = mem_write_data;
        req_read_ready_nxt    = req_read_ready;
        req_write_ready_nxt   = req_write_ready;
        req_read_data_nxt     = req_read_data;

        case (state)
            IDLE: begin
                if (scan_found) begin
                    grant_id_nxt = scan_id;
                    if (scan_read) begin
                        gnt_write_nxt        = 1'b0;
                        mem_read_valid_nxt   = 1'b1;
                        mem_read_address_nxt = req_read_address[scan_id];
                        state_nxt            = READ_WAIT;
                    end else begin
                        gnt_write_nxt         = 1'b1;
                        mem_write_valid_nxt   = 1'b1;
                        mem_write_address_nxt = req_write_address[scan_id];
                        mem_write_data_nxt    = req_write_data[scan_id];
                        state_nxt             = WRITE_WAIT;
                    end
                end
            end

            READ_WAIT: begin
                if (mem_read_ready) begin
                    req_read_data_nxt[grant_id]  = mem_read_data;
                    req_read_ready_nxt[grant_id] = 1'b1;
                    mem_read_valid_nxt           = 1'b0;
                    state_nxt                    = RELAY;
                end
            end

            WRITE_WAIT: begin
                if (mem_write_ready) begin
                    req_write_ready_nxt[grant_id] = 1'b1;
                    mem_write_valid_nxt           = 1'b0;
                    state_nxt                     = RELAY;
                end
            end

            RELAY: begin
                if (owner_released) begin
                    req_read_ready_nxt  = '0;
                    req_write_ready_nxt = '0;
                    rr_ptr_nxt          = wrap_add(grant_id, ID_W'(1));
                    state_nxt           = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state             <= IDLE;
            rr_ptr            <= '0;
            grant_id          <= '0;
            gnt_write         <= 1'b0;
            mem_read_valid    <= 1'b0;
            mem_read_address  <= '0;
            mem_write_valid   <= 1'b0;
            mem_write_address <= '0;
            mem_write_data    <= '0;
            req_read_ready    <= '0;
            req_write_ready   <= '0;
            req_read_data     <= '0;
        end else begin
            state             <= state_nxt;
            rr_ptr            <= rr_ptr_nxt;
            grant_id          <= grant_id_nxt;
            gnt_write         <= gnt_write_nxt;
            mem_read_valid    <= mem_read_valid_nxt;
            mem_read_address  <= mem_read_address_nxt;
            mem_write_valid   <= mem_write_valid_nxt;
            mem_write_address <= mem_write_address_nxt;
            mem_write_data    <= mem_write_data_nxt;
            req_read_ready    <= req_read_ready_nxt;
            req_write_ready   <= req_write_ready_nxt;
            req_read_data     <= req_read_data_nxt;
        end
    end

    // Busy whenever a transaction owns the channel.
    always_comb begin
        busy = (state != IDLE);
    end

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Directed testbench for mem_rr_arbiter (4 requesters, 8-bit address and data).
module tb_mem_rr_arbiter;

    logic             clk;
    logic             reset;
    logic [3:0]       req_read_valid;
    logic [3:0][7:0]  req_read_address;
    logic [3:0]       req_read_ready;
    logic [3:0][7:0]  req_read_data;
    logic [3:0]       req_write_valid;
    logic [3:0][7:0]  req_write_address;
    logic [3:0][7:0]  req_write_data;
    logic [3:0]       req_write_ready;
    logic             mem_read_valid;
    logic [7:0]       mem_read_address;
    logic             mem_read_ready;
    logic [7:0]       mem_read_data;
    logic             mem_write_valid;
    logic [7:0]       mem_write_address;
    logic [7:0]       mem_write_data;
    logic             mem_write_ready;
    logic             busy;
    logic [1:0]       grant_id;

    int n_vec = 0;
    int n_err = 0;
    int excl_viol = 0;

    mem_rr_arbiter #(
        .NUM_REQUESTERS(4),
        .ADDR_BITS(8),
        .DATA_BITS(8)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .req_read_valid   (req_read_valid),
        .req_read_address (req_read_address),
        .req_read_ready   (req_read_ready),
        .req_read_data    (req_read_data),
        .req_write_valid  (req_write_valid),
        .req_write_address(req_write_address),
        .req_write_data   (req_write_data),
        .req_write_ready  (req_write_ready),
        .mem_read_valid   (mem_read_valid),
        .mem_read_address (mem_read_address),
        .mem_read_ready   (mem_read_ready),
        .mem_read_data    (mem_read_data),
        .mem_write_valid  (mem_write_valid),
        .mem_write_address(mem_write_address),
        .mem_write_data   (mem_write_data),
        .mem_write_ready  (mem_write_ready),
        .busy             (busy),
        .grant_id         (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count any cycle with two ready bits or both memory valids high.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (($countones(req_read_ready | req_write_ready) > 1) ||
                (mem_read_valid === 1'b1 && mem_write_valid === 1'b1)) begin
                excl_viol++;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset             = 1'b0;
        req_read_valid    = '0;
        req_read_address  = '0;
        req_write_valid   = '0;
        req_write_address = '0;
        req_write_data    = '0;
        mem_read_ready    = 1'b0;
        mem_read_data     = '0;
        mem_write_ready   = 1'b0;
        #1;
        check_eq("rst_ctrl", 32'({mem_read_valid, mem_write_valid, busy, grant_id,
                                  req_read_ready, req_write_ready}), 32'd0);
        check_eq("rst_mem_bus", 32'({mem_read_address, mem_write_address, mem_write_data}), 32'd0);
        check_eq("rst_rd_data", 32'(req_read_data), 32'd0);
        tick();
        tick();
        reset = 1'b1;
    endtask

    // Requests already applied; DUT is idle and grants `id` on the next edge.
    task automatic run_read(input logic [1:0] id, input logic [7:0] exp_addr,
                            input logic [7:0] late_addr, input logic [7:0] rdata,
                            input int waits, input bit drop_early);
        tick();
        check_eq("rd_grant_valid", 32'(mem_read_valid), 32'd1);
        check_eq("rd_grant_id", 32'(grant_id), 32'(id));
        check_eq("rd_addr", 32'(mem_read_address), 32'(exp_addr));
        check_eq("rd_busy", 32'(busy), 32'd1);
        check_eq("rd_wr_valid_low", 32'(mem_write_valid), 32'd0);
        req_read_address[id] = late_addr;
        if (drop_early) req_read_valid[id] = 1'b0;
        repeat (waits) begin
            tick();
            check_eq("rd_wait_valid", 32'(mem_read_valid), 32'd1);
            check_eq("rd_wait_addr_held", 32'(mem_read_address), 32'(exp_addr));
            check_eq("rd_wait_no_ready", 32'(req_read_ready), 32'd0);
        end
        mem_read_ready = 1'b1;
        mem_read_data  = rdata;
        tick();
        check_eq("rd_ready_onehot", 32'(req_read_ready), 32'(4'b0001 << id));
        check_eq("rd_data", 32'(req_read_data[id]), 32'(rdata));
        check_eq("rd_mem_valid_clr", 32'(mem_read_valid), 32'd0);
        mem_read_ready     = 1'b0;
        mem_read_data      = '0;
        req_read_valid[id] = 1'b0;
        tick();
        check_eq("rd_ready_clr", 32'(req_read_ready), 32'd0);
        check_eq("rd_idle", 32'(busy), 32'd0);
        check_eq("rd_id_held", 32'(grant_id), 32'(id));
    endtask

    task automatic run_write(input logic [1:0] id, input logic [7:0] exp_addr,
                             input logic [7:0] exp_data, input int waits);
        tick();
        check_eq("wr_grant_valid", 32'(mem_write_valid), 32'd1);
        check_eq("wr_grant_id", 32'(grant_id), 32'(id));
        check_eq("wr_addr", 32'(mem_write_address), 32'(exp_addr));
        check_eq("wr_data", 32'(mem_write_data), 32'(exp_data));
        check_eq("wr_rd_valid_low", 32'(mem_read_valid), 32'd0);
        req_write_address[id] = ~exp_addr;
        req_write_data[id]    = ~exp_data;
        repeat (waits) begin
            tick();
            check_eq("wr_wait_addr_held", 32'(mem_write_address), 32'(exp_addr));
            check_eq("wr_wait_data_held", 32'(mem_write_data), 32'(exp_data));
            check_eq("wr_wait_no_ready", 32'(req_write_ready), 32'd0);
        end
        mem_write_ready = 1'b1;
        tick();
        check_eq("wr_ready_onehot", 32'(req_write_ready), 32'(4'b0001 << id));
        check_eq("wr_rd_ready_low", 32'(req_read_ready), 32'd0);
        check_eq("wr_mem_valid_clr", 32'(mem_write_valid), 32'd0);
        mem_write_ready     = 1'b0;
        req_write_valid[id] = 1'b0;
        tick();
        check_eq("wr_ready_clr", 32'(req_write_ready), 32'd0);
        check_eq("wr_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [1:0] g;
        int order [5];
        order = '{0, 1, 2, 3, 0};

        do_reset();

        // Requester 2 reads 0x10; memory answers 0x5A on the third cycle.
        req_read_address[2] = 8'h10;
        req_read_valid[2]   = 1'b1;
        run_read(2'd2, 8'h10, 8'h10, 8'h5A, 2, 1'b0);

        // All four requesters keep reading: grants rotate 0,1,2,3,0.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req_read_address[2'(i)] = 8'h40 + 8'(i);
        end
        req_read_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            g = 2'(order[k]);
            run_read(g, 8'h40 + 8'(g), 8'hEE, 8'hC0 + 8'(k), 0, 1'b0);
            req_read_address[g] = 8'h40 + 8'(g);
            req_read_valid[g]   = 1'b1;
        end

        // Requester 1 reads and writes together: read first, then the write.
        do_reset();
        req_read_address[1]  = 8'h11;
        req_read_valid[1]    = 1'b1;
        req_write_address[1] = 8'h20;
        req_write_data[1]    = 8'h33;
        req_write_valid[1]   = 1'b1;
        run_read(2'd1, 8'h11, 8'h12, 8'h77, 1, 1'b0);
        run_write(2'd1, 8'h20, 8'h33, 1);

        // Requester 0 changes its address from 0x04 to 0x08 while waiting.
        req_read_address[0] = 8'h04;
        req_read_valid[0]   = 1'b1;
        run_read(2'd0, 8'h04, 8'h08, 8'h99, 2, 1'b0);

        // Reset during a write: everything clears immediately, no ready pulse.
        req_write_address[2] = 8'h55;
        req_write_data[2]    = 8'h66;
        req_write_valid[2]   = 1'b1;
        tick();
        check_eq("mid_wr_valid", 32'(mem_write_valid), 32'd1);
        check_eq("mid_wr_id", 32'(grant_id), 32'd2);
        tick();
        check_eq("mid_wr_wait", 32'(mem_write_valid), 32'd1);
        reset           = 1'b0;
        mem_write_ready = 1'b1;
        #1;
        check_eq("async_rst_ctrl", 32'({mem_write_valid, mem_read_valid, busy, grant_id}), 32'd0);
        check_eq("async_rst_bus", 32'({mem_write_address, mem_write_data}), 32'd0);
        tick();
        check_eq("async_rst_no_ready", 32'({req_write_ready, req_read_ready}), 32'd0);
        req_write_valid     = '0;
        mem_write_ready     = 1'b0;
        req_read_address[0] = 8'h0A;
        req_read_address[3] = 8'h3A;
        req_read_valid      = 4'b1001;
        reset               = 1'b1;
        run_read(2'd0, 8'h0A, 8'h0B, 8'h81, 0, 1'b0);
        run_read(2'd3, 8'h3A, 8'h3B, 8'h82, 0, 1'b0);

        // With requester 0 quiet, requester 3 gets the first grant after reset.
        do_reset();
        req_read_address[3] = 8'h3C;
        req_read_valid      = 4'b1000;
        run_read(2'd3, 8'h3C, 8'h3D, 8'h9C, 0, 1'b0);

        // Requester 3 drops valid while waiting; afterwards the pointer wraps to 0.
        req_read_address[1] = 8'h21;
        req_read_valid[1]   = 1'b1;
        run_read(2'd1, 8'h21, 8'h22, 8'h55, 0, 1'b0);
        req_read_address[3] = 8'h30;
        req_read_valid[3]   = 1'b1;
        run_read(2'd3, 8'h30, 8'h31, 8'hE3, 2, 1'b1);
        req_read_address[1] = 8'h21;
        req_read_address[3] = 8'h30;
        req_read_valid      = 4'b1010;
        run_read(2'd1, 8'h21, 8'h5E, 8'h12, 0, 1'b0);
        run_read(2'd3, 8'h30, 8'h6E, 8'h13, 0, 1'b0);

        tick();
        check_eq("exclusive_ready_valid", 32'(excl_viol), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
